// File: rtl/soc_bus_fabric.sv
`default_nettype none
// ============================================================================
// Module   : soc_bus_fabric
// Purpose  : CPU data-port interconnect with base/mask slave decode, per-slave
//            ready merge into one CPU stall, unmapped-access trap and sticky
//            error capture. Optional hung-slave watchdog: BUS_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module soc_bus_fabric #(
    parameter int                         NUM_SLAVES     = 4,
    parameter int                         DATA_W         = 32,
    parameter logic [32*NUM_SLAVES-1:0]   SLAVE_BASE     = {NUM_SLAVES{32'h0}},
    parameter logic [32*NUM_SLAVES-1:0]   SLAVE_MASK     = {NUM_SLAVES{32'hFFFF_0000}},
    parameter int                         TIMEOUT_CYCLES = 255,
    parameter logic [DATA_W-1:0]          ERR_RDATA      = 32'hDEADBEEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [31:0]                  data_addr,
    input  logic                         ren,
    input  logic                         wen,
    input  logic [DATA_W-1:0]            data_out,
    input  logic [DATA_W/8-1:0]          byte_select,
    output logic [DATA_W-1:0]            data_in,
    output logic                         ready,
    output logic [NUM_SLAVES-1:0]        slv_ren,
    output logic [NUM_SLAVES-1:0]        slv_wen,
    output logic [31:0]                  slv_addr,
    output logic [DATA_W-1:0]            slv_wdata,
    output logic [DATA_W/8-1:0]          slv_be,
    input  logic [NUM_SLAVES*DATA_W-1:0] slv_rdata,
    input  logic [NUM_SLAVES-1:0]        slv_ready,
    output logic                         bus_err,
    output logic [31:0]                  err_addr,
    input  logic                         err_clr
);

    localparam int c_be_w  = DATA_W / 8;
    localparam int c_idx_w = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [c_idx_w-1:0]      idx_q, idx_d;
    logic                    wr_q, wr_d;
    logic [31:0]             addr_q, addr_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic [c_be_w-1:0]       be_q, be_d;
    logic [DATA_W-1:0]       data_in_q, data_in_d;
    logic [NUM_SLAVES-1:0]   ren_q, ren_d;
    logic [NUM_SLAVES-1:0]   wen_q, wen_d;
    logic                    bus_err_q, bus_err_d;
    logic [31:0]             err_addr_q, err_addr_d;

`ifdef BUS_TIMEOUT_EN
    localparam int                 c_cnt_w    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);
    logic [c_cnt_w-1:0]            cnt_q, cnt_d;
`endif

    logic                    w_req;
    logic [NUM_SLAVES-1:0]   w_hit;
    logic                    w_hit_any;
    logic [c_idx_w-1:0]      w_hit_idx;
    logic [DATA_W-1:0]       w_rdata [NUM_SLAVES];
    logic                    w_sel_ready;
    logic                    w_err_set;
    logic [31:0]             w_err_src;

    assign w_req = ren | wen;

    generate
        for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_slave
            assign w_hit[i]   = (data_addr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32];
            assign w_rdata[i] = slv_rdata[DATA_W*i +: DATA_W];
        end
    endgenerate

    // Scan from the top down so the lowest matching index is the one left standing.
    always_comb begin
        w_hit_any = 1'b0;
        w_hit_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_hit_any = 1'b1;
                w_hit_idx = c_idx_w'(i);
            end
        end
    end

    assign w_sel_ready = slv_ready[idx_q];

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        data_in_d  = data_in_q;
        ren_d      = ren_q;
        wen_d      = wen_q;
        bus_err_d  = bus_err_q;
        err_addr_d = err_addr_q;
        w_err_set  = 1'b0;
        w_err_src  = addr_q;
`ifdef BUS_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (w_req) begin
                    idx_d   = w_hit_idx;
                    wr_d    = wen;
                    addr_d  = data_addr;
                    wdata_d = data_out;
                    be_d    = byte_select;
                    if (w_hit_any) begin
                        state_d = WAIT;
                        if (wen) wen_d[w_hit_idx] = 1'b1;
                        else     ren_d[w_hit_idx] = 1'b1;
`ifdef BUS_TIMEOUT_EN
                        cnt_d = '0;
`endif
                    end else begin
                        state_d   = DONE;
                        data_in_d = ERR_RDATA;
                        w_err_set = 1'b1;
                        w_err_src = data_addr;
                    end
                end
            end
            WAIT: begin
                if (w_sel_ready) begin
                    if (!wr_q) data_in_d = w_rdata[idx_q];
                    state_d = DONE;
                    ren_d   = '0;
                    wen_d   = '0;
                end
`ifdef BUS_TIMEOUT_EN
                else if (cnt_q == c_cnt_last) begin
                    state_d   = DONE;
                    ren_d     = '0;
                    wen_d     = '0;
                    data_in_d = ERR_RDATA;
                    w_err_set = 1'b1;
                end else begin
                    cnt_d = cnt_q + c_cnt_w'(1);
                end
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A clear in the same cycle as a new error takes precedence.
        if (err_clr) begin
            bus_err_d  = 1'b0;
            err_addr_d = '0;
        end else if (w_err_set) begin
            bus_err_d = 1'b1;
            if (!bus_err_q) err_addr_d = w_err_src;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            data_in_q  <= '0;
            ren_q      <= '0;
            wen_q      <= '0;
            bus_err_q  <= 1'b0;
            err_addr_q <= '0;
`ifdef BUS_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            data_in_q  <= data_in_d;
            ren_q      <= ren_d;
            wen_q      <= wen_d;
            bus_err_q  <= bus_err_d;
            err_addr_q <= err_addr_d;
`ifdef BUS_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign ready     = ((state_q == IDLE) && !w_req) || (state_q == DONE);
    assign data_in   = data_in_q;
    assign slv_ren   = ren_q;
    assign slv_wen   = wen_q;
    assign slv_addr  = addr_q;
    assign slv_wdata = wdata_q;
    assign slv_be    = be_q;
    assign bus_err   = bus_err_q;
    assign err_addr  = err_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_soc_bus_fabric.sv
`default_nettype none
// Testbench for soc_bus_fabric: directed scenarios plus randomized traffic
// checked against a transaction-level model of decode, latency and errors.
module tb_soc_bus_fabric;

    localparam int          NS  = 4;
    localparam int          TO  = 8;
    localparam logic [31:0] ERR = 32'hDEADBEEF;
    localparam logic [31:0] BASES [NS] = '{32'h2000_0000, 32'h1000_0000, 32'h2000_0000, 32'h3000_0000};
    localparam logic [31:0] MASKS [NS] = '{32'hFF00_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000};

    logic             clk = 1'b0;
    logic             reset;
    logic [31:0]      data_addr;
    logic             ren, wen;
    logic [31:0]      data_out;
    logic [3:0]       byte_select;
    logic [31:0]      data_in;
    logic             ready;
    logic [NS-1:0]    slv_ren, slv_wen;
    logic [31:0]      slv_addr;
    logic [31:0]      slv_wdata;
    logic [3:0]       slv_be;
    logic [NS*32-1:0] slv_rdata;
    logic [NS-1:0]    slv_ready;
    logic             bus_err;
    logic [31:0]      err_addr;
    logic             err_clr;

    // Slave-side models: fixed read data and a programmable number of wait cycles.
    logic [31:0]   srdata [NS];
    int            wait_k [NS];
    int            scnt   [NS];
    logic [NS-1:0] force_rdy;

    int n_pass  = 0;
    int n_total = 0;

    // Expected architectural state carried between transactions.
    logic [31:0] exp_data;
    logic        exp_err;
    logic [31:0] exp_err_addr;

    // Observations of the last transaction.
    int          obs_stalls;
    int          obs_ren_cnt [NS];
    int          obs_wen_cnt [NS];
    int          obs_strobes;
    bit          obs_latch_ok;
    bit          obs_done;
    logic [31:0] obs_data;

    soc_bus_fabric #(
        .NUM_SLAVES     (NS),
        .DATA_W         (32),
        .SLAVE_BASE     ({32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h2000_0000}),
        .SLAVE_MASK     ({32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFF00_0000}),
        .TIMEOUT_CYCLES (TO),
        .ERR_RDATA      (ERR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .data_addr   (data_addr),
        .ren         (ren),
        .wen         (wen),
        .data_out    (data_out),
        .byte_select (byte_select),
        .data_in     (data_in),
        .ready       (ready),
        .slv_ren     (slv_ren),
        .slv_wen     (slv_wen),
        .slv_addr    (slv_addr),
        .slv_wdata   (slv_wdata),
        .slv_be      (slv_be),
        .slv_rdata   (slv_rdata),
        .slv_ready   (slv_ready),
        .bus_err     (bus_err),
        .err_addr    (err_addr),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = 0; i < NS; i++)
            scnt[i] <= (slv_ren[i] | slv_wen[i]) ? scnt[i] + 1 : 0;
    end

    always_comb begin
        slv_ready = '0;
        for (int i = 0; i < NS; i++)
            slv_ready[i] = force_rdy[i] | ((slv_ren[i] | slv_wen[i]) && (scnt[i] >= wait_k[i]));
    end

    assign slv_rdata = {srdata[3], srdata[2], srdata[1], srdata[0]};

    function automatic int model_target(input logic [31:0] a);
        for (int i = 0; i < NS; i++)
            if ((a & MASKS[i]) == BASES[i]) return i;
        return -1;
    endfunction

    task automatic model_error(input logic [31:0] a);
        if (!exp_err) begin
            exp_err      = 1'b1;
            exp_err_addr = a;
        end
    endtask

    // Drives one CPU request (held until ready) and records what the bus did.
    task automatic run_txn(input logic [31:0] a, input bit wr, input bit both,
                           input logic [31:0] wd, input logic [3:0] be);
        obs_stalls   = 0;
        obs_strobes  = 0;
        obs_latch_ok = 1'b1;
        obs_done     = 1'b0;
        obs_data     = 'x;
        for (int j = 0; j < NS; j++) begin
            obs_ren_cnt[j] = 0;
            obs_wen_cnt[j] = 0;
        end
        data_addr   = a;
        ren         = !wr || both;
        wen         = wr;
        data_out    = wd;
        byte_select = be;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int j = 0; j < NS; j++) begin
                if (slv_ren[j]) begin obs_ren_cnt[j]++; obs_strobes++; end
                if (slv_wen[j]) begin obs_wen_cnt[j]++; obs_strobes++; end
            end
            if ((slv_ren | slv_wen) != '0 &&
                (slv_addr !== a || slv_wdata !== wd || slv_be !== be))
                obs_latch_ok = 1'b0;
            if (ready === 1'b1) begin
                obs_data = data_in;
                obs_done = 1'b1;
                break;
            end
            obs_stalls++;
        end
        @(posedge clk);
        #1;
        ren = 1'b0;
        wen = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_total++; if (data_in   !== 32'h0)  $display("FAIL rst_data_in: got %h want %h", data_in, 32'h0);    else n_pass++;
        n_total++; if (slv_ren   !== 4'h0)   $display("FAIL rst_slv_ren: got %b want %b", slv_ren, 4'h0);     else n_pass++;
        n_total++; if (slv_wen   !== 4'h0)   $display("FAIL rst_slv_wen: got %b want %b", slv_wen, 4'h0);     else n_pass++;
        n_total++; if (slv_addr  !== 32'h0)  $display("FAIL rst_slv_addr: got %h want %h", slv_addr, 32'h0);  else n_pass++;
        n_total++; if (slv_wdata !== 32'h0)  $display("FAIL rst_slv_wdata: got %h want %h", slv_wdata, 32'h0); else n_pass++;
        n_total++; if (slv_be    !== 4'h0)   $display("FAIL rst_slv_be: got %b want %b", slv_be, 4'h0);       else n_pass++;
        n_total++; if (bus_err   !== 1'b0)   $display("FAIL rst_bus_err: got %b want 0", bus_err);            else n_pass++;
        n_total++; if (err_addr  !== 32'h0)  $display("FAIL rst_err_addr: got %h want %h", err_addr, 32'h0);  else n_pass++;
        n_total++; if (ready     !== 1'b1)   $display("FAIL rst_ready: got %b want 1", ready);                else n_pass++;
        @(posedge clk);
        #1 reset = 1'b1;
        exp_data = 32'h0; exp_err = 1'b0; exp_err_addr = 32'h0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_zero_wait_read();
        srdata[1]    = 32'h1234_5678;
        force_rdy[1] = 1'b1;
        run_txn(32'h1000_0004, 1'b0, 1'b0, 32'h0, 4'hF);
        force_rdy[1] = 1'b0;
        exp_data = 32'h1234_5678;
        n_total++; if (obs_ren_cnt[1] !== 1)  $display("FAIL zw_strobe_cycles: got %0d want 1", obs_ren_cnt[1]); else n_pass++;
        n_total++; if (obs_strobes !== 1)     $display("FAIL zw_total_strobes: got %0d want 1", obs_strobes);    else n_pass++;
        n_total++; if (obs_stalls !== 2)      $display("FAIL zw_stalls: got %0d want 2", obs_stalls);            else n_pass++;
        n_total++; if (obs_data !== exp_data) $display("FAIL zw_data: got %h want %h", obs_data, exp_data);     else n_pass++;
    endtask

    task automatic test_wait_write();
        wait_k[0] = 3;
        run_txn(32'h2011_0000, 1'b1, 1'b0, 32'hA5A5_A5A5, 4'b0011);
        wait_k[0] = 0;
        n_total++; if (obs_wen_cnt[0] !== 4)  $display("FAIL ww_strobe_cycles: got %0d want 4", obs_wen_cnt[0]); else n_pass++;
        n_total++; if (obs_strobes !== 4)     $display("FAIL ww_total_strobes: got %0d want 4", obs_strobes);    else n_pass++;
        n_total++; if (obs_stalls !== 5)      $display("FAIL ww_stalls: got %0d want 5", obs_stalls);            else n_pass++;
        n_total++; if (obs_latch_ok !== 1'b1) $display("FAIL ww_latched_stable: got %b want 1", obs_latch_ok);  else n_pass++;
        n_total++; if (obs_data !== exp_data) $display("FAIL ww_data_kept: got %h want %h", obs_data, exp_data); else n_pass++;
    endtask

    task automatic test_unmapped();
        run_txn(32'hF000_0000, 1'b0, 1'b0, 32'h0, 4'hF);
        exp_data = ERR;
        model_error(32'hF000_0000);
        n_total++; if (obs_strobes !== 0)       $display("FAIL um_strobes: got %0d want 0", obs_strobes);             else n_pass++;
        n_total++; if (obs_stalls !== 1)        $display("FAIL um_stalls: got %0d want 1", obs_stalls);               else n_pass++;
        n_total++; if (obs_data !== exp_data)   $display("FAIL um_data: got %h want %h", obs_data, exp_data);        else n_pass++;
        n_total++; if (bus_err !== exp_err)     $display("FAIL um_bus_err: got %b want %b", bus_err, exp_err);       else n_pass++;
        n_total++; if (err_addr !== exp_err_addr) $display("FAIL um_err_addr: got %h want %h", err_addr, exp_err_addr); else n_pass++;

        run_txn(32'hF000_0010, 1'b0, 1'b0, 32'h0, 4'hF);
        model_error(32'hF000_0010);
        n_total++; if (err_addr !== exp_err_addr) $display("FAIL um2_err_addr: got %h want %h", err_addr, exp_err_addr); else n_pass++;
        n_total++; if (bus_err !== 1'b1)        $display("FAIL um2_bus_err: got %b want 1", bus_err);                   else n_pass++;

        err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        exp_err = 1'b0; exp_err_addr = 32'h0;
        n_total++; if (bus_err !== 1'b0)   $display("FAIL clr_bus_err: got %b want 0", bus_err);          else n_pass++;
        n_total++; if (err_addr !== 32'h0) $display("FAIL clr_err_addr: got %h want 0", err_addr);        else n_pass++;

        // Clear held across a fresh miss must keep the flag down.
        err_clr = 1'b1;
        run_txn(32'hF000_0020, 1'b0, 1'b0, 32'h0, 4'hF);
        err_clr = 1'b0;
        n_total++; if (bus_err !== 1'b0)   $display("FAIL clr_wins_bus_err: got %b want 0", bus_err);     else n_pass++;
        n_total++; if (err_addr !== 32'h0) $display("FAIL clr_wins_err_addr: got %h want 0", err_addr);   else n_pass++;
    endtask

    task automatic test_overlap();
        srdata[0] = 32'h0BAD_F00D;
        srdata[2] = 32'h2222_2222;
        run_txn(32'h2000_0000, 1'b0, 1'b0, 32'h0, 4'hF);
        exp_data = 32'h0BAD_F00D;
        n_total++; if (obs_ren_cnt[0] !== 1)  $display("FAIL ov_slave0: got %0d want 1", obs_ren_cnt[0]); else n_pass++;
        n_total++; if (obs_ren_cnt[2] !== 0)  $display("FAIL ov_slave2: got %0d want 0", obs_ren_cnt[2]); else n_pass++;
        n_total++; if (obs_data !== exp_data) $display("FAIL ov_data: got %h want %h", obs_data, exp_data); else n_pass++;
    endtask

    task automatic test_hung_slave();
        wait_k[3] = 100000;
        srdata[3] = 32'h3333_3333;
`ifdef BUS_TIMEOUT_EN
        run_txn(32'h3000_0040, 1'b0, 1'b0, 32'h0, 4'hF);
        exp_data = ERR;
        model_error(32'h3000_0040);
        n_total++; if (obs_ren_cnt[3] !== TO)     $display("FAIL to_strobe_cycles: got %0d want %0d", obs_ren_cnt[3], TO); else n_pass++;
        n_total++; if (obs_stalls !== TO + 1)     $display("FAIL to_stalls: got %0d want %0d", obs_stalls, TO + 1);       else n_pass++;
        n_total++; if (obs_data !== exp_data)     $display("FAIL to_data: got %h want %h", obs_data, exp_data);          else n_pass++;
        n_total++; if (bus_err !== exp_err)       $display("FAIL to_bus_err: got %b want %b", bus_err, exp_err);         else n_pass++;
        n_total++; if (err_addr !== exp_err_addr) $display("FAIL to_err_addr: got %h want %h", err_addr, exp_err_addr);  else n_pass++;
`else
        data_addr = 32'h3000_0040;
        ren       = 1'b1;
        repeat (1000) @(posedge clk);
        @(negedge clk);
        n_total++; if (ready !== 1'b0)     $display("FAIL hang_ready: got %b want 0", ready);          else n_pass++;
        n_total++; if (slv_ren !== 4'b1000) $display("FAIL hang_strobe: got %b want 1000", slv_ren);  else n_pass++;
        force_rdy[3] = 1'b1;
        obs_done = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ready === 1'b1) begin obs_done = 1'b1; break; end
        end
        exp_data = 32'h3333_3333;
        n_total++; if (obs_done !== 1'b1)    $display("FAIL hang_release: got %b want 1", obs_done);             else n_pass++;
        n_total++; if (data_in !== exp_data) $display("FAIL hang_data: got %h want %h", data_in, exp_data);     else n_pass++;
        @(posedge clk);
        #1;
        ren          = 1'b0;
        force_rdy[3] = 1'b0;
`endif
        wait_k[3] = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_wait();
        wait_k[3] = 100000;
        data_addr = 32'h3000_0100;
        ren       = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b0;
        ren   = 1'b0;
        #1;
        exp_data = 32'h0; exp_err = 1'b0; exp_err_addr = 32'h0;
        n_total++; if (slv_ren !== 4'h0) $display("FAIL rmw_strobe: got %b want 0", slv_ren); else n_pass++;
        n_total++; if (ready !== 1'b1)   $display("FAIL rmw_ready: got %b want 1", ready);    else n_pass++;
        wait_k[3] = 0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        srdata[1] = 32'hCAFE_0001;
        run_txn(32'h1000_0008, 1'b0, 1'b0, 32'h0, 4'hF);
        n_total++; if (obs_stalls !== 2)            $display("FAIL b2b_first_stalls: got %0d want 2", obs_stalls);     else n_pass++;
        n_total++; if (obs_data !== 32'hCAFE_0001)  $display("FAIL b2b_first_data: got %h want cafe0001", obs_data);  else n_pass++;
        srdata[1] = 32'hCAFE_0002;
        run_txn(32'h1000_000C, 1'b0, 1'b0, 32'h0, 4'hF);
        exp_data = 32'hCAFE_0002;
        n_total++; if (obs_stalls !== 2)      $display("FAIL b2b_second_stalls: got %0d want 2", obs_stalls);       else n_pass++;
        n_total++; if (obs_data !== exp_data) $display("FAIL b2b_second_data: got %h want %h", obs_data, exp_data); else n_pass++;
    endtask

    task automatic test_random_traffic();
        logic [31:0] pfx [6];
        logic [31:0] a, wd;
        logic [3:0]  be;
        bit          wr, both;
        int          t, k, er, ew;
        pfx = '{32'h1000_0000, 32'h2000_0000, 32'h2055_0000, 32'h3000_0000, 32'hF000_0000, 32'h1001_0000};
        for (int n = 0; n < 24; n++) begin
            a    = pfx[$urandom_range(0, 5)] | ($urandom & 32'h0000_FFFC);
            wr   = 1'($urandom_range(0, 1));
            both = wr && ($urandom_range(0, 1) == 1);
            wd   = $urandom;
            be   = 4'($urandom_range(0, 15));
            k    = $urandom_range(0, 4);
            t    = model_target(a);
            for (int j = 0; j < NS; j++) begin
                srdata[j] = $urandom;
                wait_k[j] = k;
            end
            force_rdy = 4'($urandom);
            if (t >= 0) force_rdy[t] = 1'b0;
            run_txn(a, wr, both, wd, be);
            force_rdy = '0;
            if (t < 0) begin
                exp_data = ERR;
                model_error(a);
            end else if (!wr) begin
                exp_data = srdata[t];
            end
            n_total++; if (obs_stalls !== ((t < 0) ? 1 : 2 + k))
                $display("FAIL rnd_stalls[%0d]: got %0d want %0d", n, obs_stalls, (t < 0) ? 1 : 2 + k); else n_pass++;
            n_total++; if (obs_data !== exp_data)
                $display("FAIL rnd_data[%0d]: got %h want %h", n, obs_data, exp_data); else n_pass++;
            n_total++; if (obs_latch_ok !== 1'b1)
                $display("FAIL rnd_latched[%0d]: got %b want 1", n, obs_latch_ok); else n_pass++;
            n_total++; if (bus_err !== exp_err)
                $display("FAIL rnd_bus_err[%0d]: got %b want %b", n, bus_err, exp_err); else n_pass++;
            n_total++; if (err_addr !== exp_err_addr)
                $display("FAIL rnd_err_addr[%0d]: got %h want %h", n, err_addr, exp_err_addr); else n_pass++;
            for (int j = 0; j < NS; j++) begin
                er = (j == t && !wr) ? k + 1 : 0;
                ew = (j == t &&  wr) ? k + 1 : 0;
                n_total++; if (obs_ren_cnt[j] !== er)
                    $display("FAIL rnd_ren[%0d][%0d]: got %0d want %0d", n, j, obs_ren_cnt[j], er); else n_pass++;
                n_total++; if (obs_wen_cnt[j] !== ew)
                    $display("FAIL rnd_wen[%0d][%0d]: got %0d want %0d", n, j, obs_wen_cnt[j], ew); else n_pass++;
            end
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        reset       = 1'b0;
        ren         = 1'b0;
        wen         = 1'b0;
        data_addr   = 32'h0;
        data_out    = 32'h0;
        byte_select = 4'h0;
        err_clr     = 1'b0;
        force_rdy   = '0;
        for (int i = 0; i < NS; i++) begin
            srdata[i] = 32'h0;
            wait_k[i] = 0;
        end
        exp_data = 32'h0; exp_err = 1'b0; exp_err_addr = 32'h0;
        repeat (2) @(posedge clk);

        test_reset();
        test_zero_wait_read();
        test_wait_write();
        test_unmapped();
        test_overlap();
        test_hung_slave();
        test_reset_mid_wait();
        test_back_to_back();
        test_random_traffic();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
